// File: rtl/sram_access_ctrl.sv
// Sequences each 32-bit MEM-stage load/store into two 16-bit SRAM accesses
// (low half first), holding ready low until the whole word has been moved.
module sram_access_ctrl #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] DATA_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEMread,
  input  logic        MEMwrite,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] MEM_result,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [16:0] r_widx;
  logic [31:0] r_data;
  logic        r_wr;
  logic [15:0] r_lo;

  logic        w_req;
  logic        w_last;
  logic [16:0] w_widx;

  assign w_req  = MEMread | MEMwrite;
  assign w_last = (r_cnt == LAST);
  // Word index wraps modulo the 128K-word SRAM.
  assign w_widx = 17'((address - DATA_BASE) >> 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Strobes decode straight from state so reset drops them without a clock.
  always_comb begin
    w_next      = r_state;
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (r_state)
      S_IDLE: begin
        ready = ~w_req;
        if (w_req) w_next = S_LO;
      end
      S_LO: begin
        sram_addr = {r_widx, 1'b0};
        if (r_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = r_data[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
        if (w_last) w_next = S_HI;
      end
      S_HI: begin
        sram_addr = {r_widx, 1'b1};
        if (r_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = r_data[31:16];
        end else begin
          sram_oe_n = 1'b0;
        end
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        ready  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 4'd0;
      r_widx     <= 17'd0;
      r_data     <= 32'd0;
      r_wr       <= 1'b0;
      r_lo       <= 16'd0;
      MEM_result <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_cnt  <= 4'd0;
            r_widx <= w_widx;
            r_data <= data;
            r_wr   <= MEMwrite;
          end
        end
        S_LO, S_HI: begin
          r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
          if (w_last && !r_wr) begin
            if (r_state == S_LO) r_lo       <= sram_dq_in;
            else                 MEM_result <= {sram_dq_in, r_lo};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: two instances (1 and 3 wait cycles) share stimulus;
// a phase-count model predicts every output each cycle, plus literal spot checks.
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd  = 1'b0;
  logic        wr  = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] dat  = 32'd0;

  logic [31:0] res  [2];
  logic        rdy  [2];
  logic [17:0] sa   [2];
  logic [15:0] dqo  [2];
  logic [15:0] dqi  [2];
  logic        dqoe [2];
  logic        wen  [2];
  logic        oen  [2];

  logic [15:0] mem  [2][256];
  logic [31:0] gold [2][64];

  int          m_ph   [2];
  logic [16:0] m_widx [2];
  logic [31:0] m_dat  [2];
  logic        m_wr   [2];
  logic [31:0] m_res  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar u = 0; u < 2; u++) begin : g_u
    sram_access_ctrl #(.WAIT_CYCLES(u == 0 ? 1 : 3), .DATA_BASE(32'd1024)) dut (
      .clk(clk), .rst(rst), .MEMread(rd), .MEMwrite(wr),
      .address(addr), .data(dat), .MEM_result(res[u]), .ready(rdy[u]),
      .sram_addr(sa[u]), .sram_dq_out(dqo[u]), .sram_dq_in(dqi[u]),
      .sram_dq_oe(dqoe[u]), .sram_we_n(wen[u]), .sram_oe_n(oen[u])
    );
    assign dqi[u] = oen[u] ? 16'h0 : mem[u][sa[u][7:0]];
  end

  function automatic int wu(int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic logic [16:0] widx_of(logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return o[18:2];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // SRAM array per instance
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst) begin
        for (int i = 0; i < 256; i++) mem[u][i] <= 16'hA000 + 16'(i);
      end else if (!wen[u]) begin
        mem[u][sa[u][7:0]] <= dqo[u];
      end
    end
  end

  // Model: phase 0 = idle; 1..W low half; W+1..2W high half; 2W+1 done.
  always @(posedge clk or negedge rst) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst) begin
        m_ph[u]   <= 0;
        m_widx[u] <= 17'd0;
        m_dat[u]  <= 32'd0;
        m_wr[u]   <= 1'b0;
        m_res[u]  <= 32'd0;
        for (int w = 0; w < 64; w++)
          gold[u][w] <= {16'hA000 + 16'(2*w + 1), 16'hA000 + 16'(2*w)};
      end else if (m_ph[u] == 0) begin
        if (rd | wr) begin
          m_ph[u]   <= 1;
          m_widx[u] <= widx_of(addr);
          m_dat[u]  <= dat;
          m_wr[u]   <= wr;
        end
      end else if (m_ph[u] == 2*wu(u) + 1) begin
        m_ph[u] <= 0;
      end else begin
        m_ph[u] <= m_ph[u] + 1;
        if (m_ph[u] == 2*wu(u)) begin
          if (m_wr[u]) gold[u][m_widx[u][5:0]] <= m_dat[u];
          else         m_res[u] <= gold[u][m_widx[u][5:0]];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int   w;
      logic act;
      logic hi;
      w   = wu(u);
      act = (m_ph[u] >= 1) && (m_ph[u] <= 2*w);
      hi  = (m_ph[u] > w);
      chk($sformatf("u%0d ready", u), 32'(rdy[u]),
          (m_ph[u] == 0) ? 32'(!(rd | wr)) : 32'(m_ph[u] == 2*w + 1));
      chk($sformatf("u%0d sram_addr", u), 32'(sa[u]), act ? 32'({m_widx[u], hi}) : 32'd0);
      chk($sformatf("u%0d we_n", u), 32'(wen[u]), act ? 32'(!m_wr[u]) : 32'd1);
      chk($sformatf("u%0d oe_n", u), 32'(oen[u]), act ? 32'(m_wr[u]) : 32'd1);
      chk($sformatf("u%0d dq_oe", u), 32'(dqoe[u]), 32'(act && m_wr[u]));
      if (!act || m_wr[u])
        chk($sformatf("u%0d dq_out", u), 32'(dqo[u]),
            act ? 32'(hi ? m_dat[u][31:16] : m_dat[u][15:0]) : 32'd0);
      chk($sformatf("u%0d MEM_result", u), res[u], m_res[u]);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    #5;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      tick;
      rd = 1'b0;
      wr = 1'b0;
    end
  endtask

  initial begin
    // reset held with a pending load
    rd = 1'b1; addr = 32'd1024;
    tick; tick; mid;
    chk("rst MEM_result", res[0], 32'd0);
    chk("rst we_n", 32'(wen[0]), 32'd1);
    chk("rst oe_n", 32'(oen[0]), 32'd1);
    chk("rst ready", 32'(rdy[0]), 32'd0);
    tick; rst = 1'b1; mid;
    chk("release ready", 32'(rdy[0]), 32'd0);
    tick; rd = 1'b0; mid;
    chk("release started", 32'(oen[0]), 32'd0);
    idle(8);

    // store 0xDEADBEEF @1024, request dropped during LO
    tick; wr = 1'b1; addr = 32'd1024; dat = 32'hDEADBEEF; mid;
    chk("st c0 ready", 32'(rdy[0]), 32'd0);
    tick; wr = 1'b0; mid;
    chk("st c1 addr", 32'(sa[0]), 32'd0);
    chk("st c1 we_n", 32'(wen[0]), 32'd0);
    chk("st c1 dq", 32'(dqo[0]), 32'h0000BEEF);
    tick; mid;
    chk("st c2 addr", 32'(sa[0]), 32'd1);
    chk("st c2 dq", 32'(dqo[0]), 32'h0000DEAD);
    chk("st c2 ready", 32'(rdy[0]), 32'd0);
    tick; mid;
    chk("st c3 ready", 32'(rdy[0]), 32'd1);
    chk("st c3 we_n", 32'(wen[0]), 32'd1);
    idle(6);
    chk("sram hw0", 32'(mem[0][0]), 32'h0000BEEF);
    chk("sram hw1", 32'(mem[0][1]), 32'h0000DEAD);

    // load it back
    tick; rd = 1'b1; mid;
    chk("ld c0 ready", 32'(rdy[0]), 32'd0);
    tick; rd = 1'b0;
    tick; tick; mid;
    chk("ld done result", res[0], 32'hDEADBEEF);
    chk("ld done ready", 32'(rdy[0]), 32'd1);
    idle(6);

    // 3-wait instance: store @1032 -> halfwords 4 then 5
    tick; wr = 1'b1; addr = 32'd1032; dat = 32'hCAFEF00D; mid;
    chk("w3 c0 ready", 32'(rdy[1]), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      tick; wr = 1'b0; mid;
      chk($sformatf("w3 c%0d addr", k), 32'(sa[1]), (k <= 3) ? 32'd4 : ((k <= 6) ? 32'd5 : 32'd0));
      chk($sformatf("w3 c%0d we_n", k), 32'(wen[1]), (k <= 6) ? 32'd0 : 32'd1);
      chk($sformatf("w3 c%0d ready", k), 32'(rdy[1]), (k == 7) ? 32'd1 : 32'd0);
    end
    idle(2);
    chk("w3 sram hw4", 32'(mem[1][4]), 32'h0000F00D);
    chk("w3 sram hw5", 32'(mem[1][5]), 32'h0000CAFE);

    // back-to-back loads 1028 then 1036, request held across DONE
    tick; rd = 1'b1; addr = 32'd1028;
    tick; tick; tick; mid;
    chk("b2b first", res[0], 32'hA003A002);
    chk("b2b first ready", 32'(rdy[0]), 32'd1);
    tick; addr = 32'd1036; mid;
    chk("b2b gap ready", 32'(rdy[0]), 32'd0);
    chk("b2b hold", res[0], 32'hA003A002);
    tick; rd = 1'b0;
    tick; tick; mid;
    chk("b2b second", res[0], 32'hA007A006);
    chk("b2b second ready", 32'(rdy[0]), 32'd1);
    idle(2);

    // read+write together is a write
    tick; rd = 1'b1; wr = 1'b1; addr = 32'd1024; dat = 32'h12345678;
    tick; rd = 1'b0; wr = 1'b0;
    idle(8);
    tick; rd = 1'b1;
    tick; rd = 1'b0;
    tick; tick; mid;
    chk("rw load", res[0], 32'h12345678);
    idle(6); mid;
    chk("rw load w3", res[1], 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
